// File: rtl/prbs_pack.sv
// Shared PRBS definitions: polynomial select, tap positions, sequence lengths.
// Used by both the generator and the receive-side checker.
package prbs_pack;

    localparam int unsigned STATE_W = 31;

    typedef enum logic [2:0] {
        PRBS7  = 3'd0,
        PRBS9  = 3'd1,
        PRBS15 = 3'd2,
        PRBS23 = 3'd3,
        PRBS31 = 3'd4
    } prbs_mode_t;

    localparam int unsigned PRBS7_LEN  = 7;
    localparam int unsigned PRBS7_TA   = 7;
    localparam int unsigned PRBS7_TB   = 6;
    localparam int unsigned PRBS9_LEN  = 9;
    localparam int unsigned PRBS9_TA   = 9;
    localparam int unsigned PRBS9_TB   = 5;
    localparam int unsigned PRBS15_LEN = 15;
    localparam int unsigned PRBS15_TA  = 15;
    localparam int unsigned PRBS15_TB  = 14;
    localparam int unsigned PRBS23_LEN = 23;
    localparam int unsigned PRBS23_TA  = 23;
    localparam int unsigned PRBS23_TB  = 18;
    localparam int unsigned PRBS31_LEN = 31;
    localparam int unsigned PRBS31_TA  = 31;
    localparam int unsigned PRBS31_TB  = 28;

    // Undefined modes 5..7 fall through to PRBS31.
    function automatic logic [4:0] prbs_len(input logic [2:0] mode);
        case (prbs_mode_t'(mode))
            PRBS7:   return 5'(PRBS7_LEN);
            PRBS9:   return 5'(PRBS9_LEN);
            PRBS15:  return 5'(PRBS15_LEN);
            PRBS23:  return 5'(PRBS23_LEN);
            default: return 5'(PRBS31_LEN);
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap_a(input logic [2:0] mode);
        case (prbs_mode_t'(mode))
            PRBS7:   return 5'(PRBS7_TA);
            PRBS9:   return 5'(PRBS9_TA);
            PRBS15:  return 5'(PRBS15_TA);
            PRBS23:  return 5'(PRBS23_TA);
            default: return 5'(PRBS31_TA);
        endcase
    endfunction

    function automatic logic [4:0] prbs_tap_b(input logic [2:0] mode);
        case (prbs_mode_t'(mode))
            PRBS7:   return 5'(PRBS7_TB);
            PRBS9:   return 5'(PRBS9_TB);
            PRBS15:  return 5'(PRBS15_TB);
            PRBS23:  return 5'(PRBS23_TB);
            default: return 5'(PRBS31_TB);
        endcase
    endfunction

    // All-ones over the active L bits of the state register.
    function automatic logic [STATE_W-1:0] prbs_mask(input logic [2:0] mode);
        return STATE_W'((32'h1 << prbs_len(mode)) - 32'h1);
    endfunction

endpackage

// File: rtl/prbs_generator_if.sv
// Control and data bundle of the PRBS generator; master is the controller side.
interface prbs_generator_if #(
    parameter int unsigned n_prbs     = 32,
    parameter int unsigned n_channels = 16
);
    localparam int unsigned LANE_W = (n_channels > 1) ? $clog2(n_channels) : 1;

    logic                  en;
    logic                  load;
    logic [2:0]            prbs_mode;
    logic [n_prbs-1:0]     init_vals;
    logic                  inj_en;
    logic [15:0]           err_period;
    logic [LANE_W-1:0]     err_lane;
    logic [n_channels-1:0] out_bits;
    logic                  out_valid;
    logic [15:0]           inj_count;

    modport master (
        output en, load, prbs_mode, init_vals, inj_en, err_period, err_lane,
        input  out_bits, out_valid, inj_count
    );

    modport slave (
        input  en, load, prbs_mode, init_vals, inj_en, err_period, err_lane,
        output out_bits, out_valid, inj_count
    );
endinterface

// File: rtl/prbs_lfsr_unroll.sv
// Combinational n_channels-step unroll of the Fibonacci LFSR; bit 0 of word is the
// first step. Bits of the state above the active length are forced to zero.
module prbs_lfsr_unroll
    import prbs_pack::*;
#(
    parameter int unsigned n_channels = 16
) (
    input  logic [STATE_W-1:0]    state,
    input  logic [2:0]            mode,
    output logic [STATE_W-1:0]    next_state,
    output logic [n_channels-1:0] word
);
    logic [STATE_W-1:0] s;
    logic [STATE_W-1:0] mask;
    logic [4:0]         ta;
    logic [4:0]         tb;
    logic               nb;

    always_comb begin
        mask = prbs_mask(mode);
        ta   = prbs_tap_a(mode) - 5'd1;
        tb   = prbs_tap_b(mode) - 5'd1;
        s    = state;
        nb   = 1'b0;
        word = '0;
        for (int unsigned i = 0; i < n_channels; i++) begin
            nb      = s[ta] ^ s[tb];
            word[i] = nb;
            s       = {s[STATE_W-2:0], nb} & mask;
        end
        next_state = s;
    end
endmodule

// File: rtl/prbs_generator.sv
// Parallel PRBS source: seed/polynomial load, n_channels bits per enabled cycle,
// and periodic single-bit error injection on the output word.
module prbs_generator
    import prbs_pack::*;
#(
    parameter int unsigned n_prbs     = 32,
    parameter int unsigned n_channels = 16
) (
    input  logic            clk,
    input  logic            rstb,
    prbs_generator_if.slave bus
);
    logic [STATE_W-1:0]     state_r;
    logic [STATE_W-1:0]     state_nxt;
    logic [2:0]             mode_r;
    logic [n_channels-1:0]  word;
    logic [n_channels-1:0]  flip;
    logic [n_channels-1:0]  out_bits_r;
    logic                   out_valid_r;
    logic [15:0]            inj_count_r;
    logic [15:0]            word_cnt_r;
    logic                   inj_active;
    logic                   inject;
    logic [STATE_W-1:0]     seed;
    logic [n_prbs+30:0]     init_ext;
    logic                   unused_init;

    prbs_lfsr_unroll #(.n_channels(n_channels)) u_unroll (
        .state      (state_r),
        .mode       (mode_r),
        .next_state (state_nxt),
        .word       (word)
    );

    // Zero-extend so narrow n_prbs still yields a full-width seed.
    assign init_ext    = {31'b0, bus.init_vals};
    assign unused_init = ^init_ext[n_prbs+30:STATE_W];

    // Masked seed with lock-up guard: an all-zero seed becomes all-ones.
    always_comb begin
        seed = init_ext[STATE_W-1:0] & prbs_mask(bus.prbs_mode);
        if (seed == '0) begin
            seed = prbs_mask(bus.prbs_mode);
        end
    end

    // ">=" also covers err_period shrinking below the running count.
    always_comb begin
        inj_active = bus.inj_en && (bus.err_period != 16'd0);
        inject     = inj_active && (word_cnt_r >= (bus.err_period - 16'd1));
        flip       = inject ? (n_channels'(1) << bus.err_lane) : '0;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_r     <= STATE_W'(7'h7F);
            mode_r      <= 3'd0;
            out_bits_r  <= '0;
            out_valid_r <= 1'b0;
            inj_count_r <= 16'd0;
            word_cnt_r  <= 16'd0;
        end else if (bus.load) begin
            mode_r      <= bus.prbs_mode;
            state_r     <= seed;
            out_valid_r <= 1'b0;
            inj_count_r <= 16'd0;
            word_cnt_r  <= 16'd0;
        end else if (bus.en) begin
            state_r     <= state_nxt;
            out_bits_r  <= word ^ flip;
            out_valid_r <= 1'b1;
            if (inj_active) begin
                if (inject) begin
                    word_cnt_r <= 16'd0;
                    if (inj_count_r != 16'hFFFF) begin
                        inj_count_r <= inj_count_r + 16'd1;
                    end
                end else begin
                    word_cnt_r <= word_cnt_r + 16'd1;
                end
            end
        end else begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.out_bits  = out_bits_r;
    assign bus.out_valid = out_valid_r;
    assign bus.inj_count = inj_count_r;
endmodule

// File: tb/tb_prbs_generator.sv
// Directed bench for prbs_generator: vector table plus scripted multi-cycle
// sequences, checked against hand values and a bit-serial reference LFSR.
module tb_prbs_generator;
    localparam int unsigned NCH = 16;
    localparam int K_HOLD  = 0;
    localparam int K_MODEL = 1;
    localparam int K_CONST = 2;

    logic clk = 1'b0;
    logic rstb;
    always #5 clk = ~clk;

    prbs_generator_if #(.n_prbs(32), .n_channels(NCH)) bus ();

    prbs_generator #(.n_prbs(32), .n_channels(NCH)) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    longint m_st;
    longint m_mask;
    int     m_ta;
    int     m_tb;

    typedef struct {
        logic        ld;
        logic        en;
        logic [2:0]  mode;
        logic [31:0] seed;
        logic        exp_valid;
        int          kind;
        logic [15:0] cbits;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference LFSR using the tap numbers straight from the polynomial list.
    task automatic m_load(input logic [2:0] mode, input logic [31:0] seed);
        int len;
        case (mode)
            3'd0:    begin len = 7;  m_ta = 7;  m_tb = 6;  end
            3'd1:    begin len = 9;  m_ta = 9;  m_tb = 5;  end
            3'd2:    begin len = 15; m_ta = 15; m_tb = 14; end
            3'd3:    begin len = 23; m_ta = 23; m_tb = 18; end
            default: begin len = 31; m_ta = 31; m_tb = 28; end
        endcase
        m_mask = (longint'(1) << len) - 1;
        m_st   = longint'(seed) & m_mask;
        if (m_st == 0) m_st = m_mask;
    endtask

    task automatic m_word(output logic [NCH-1:0] w);
        longint nb;
        w = '0;
        for (int i = 0; i < NCH; i++) begin
            nb   = ((m_st >> (m_ta - 1)) ^ (m_st >> (m_tb - 1))) & 1;
            w[i] = nb[0];
            m_st = ((m_st << 1) | nb) & m_mask;
        end
    endtask

    task automatic step(input logic ld, input logic e);
        bus.load = ld;
        bus.en   = e;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [NCH-1:0] w;
        logic [NCH-1:0] exp_last;
        logic [NCH-1:0] first;
        logic [NCH-1:0] flipm;
        int bad;
        logic       s_inj [13];
        logic [15:0] s_per [13];
        logic       s_flip[13];

        tbl[0]  = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_MODEL, 16'h0};
        tbl[1]  = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_MODEL, 16'h0};
        tbl[2]  = '{1'b0, 1'b0, 3'd0, 32'h0,         1'b0, K_HOLD,  16'h0};
        tbl[3]  = '{1'b1, 1'b0, 3'd0, 32'h1,         1'b0, K_HOLD,  16'h0};
        tbl[4]  = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_CONST, 16'h2860};
        tbl[5]  = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_MODEL, 16'h0};
        tbl[6]  = '{1'b1, 1'b1, 3'd2, 32'h0,         1'b0, K_HOLD,  16'h0};
        tbl[7]  = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_CONST, 16'h4000};
        tbl[8]  = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_MODEL, 16'h0};
        tbl[9]  = '{1'b1, 1'b0, 3'd4, 32'h8000_0001, 1'b0, K_HOLD,  16'h0};
        tbl[10] = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_MODEL, 16'h0};
        tbl[11] = '{1'b1, 1'b0, 3'd6, 32'h1234_5678, 1'b0, K_HOLD,  16'h0};
        tbl[12] = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_MODEL, 16'h0};
        tbl[13] = '{1'b1, 1'b0, 3'd1, 32'h0000_01AB, 1'b0, K_HOLD,  16'h0};
        tbl[14] = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_MODEL, 16'h0};
        tbl[15] = '{1'b1, 1'b0, 3'd3, 32'h00AB_CDEF, 1'b0, K_HOLD,  16'h0};
        tbl[16] = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_MODEL, 16'h0};
        tbl[17] = '{1'b0, 1'b1, 3'd0, 32'h0,         1'b1, K_MODEL, 16'h0};

        // Scripted injection continuation: {inj_en, err_period, expect flip}.
        s_inj  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        s_per  = '{16'd4, 16'd4, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd4, 16'd4, 16'd4, 16'd0};
        s_flip = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        bus.en = 1'b0; bus.load = 1'b0; bus.prbs_mode = 3'd0; bus.init_vals = '0;
        bus.inj_en = 1'b0; bus.err_period = 16'd0; bus.err_lane = '0;
        rstb = 1'b0;
        #12;
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_bits",  32'(bus.out_bits),  32'h0);
        chk("rst_inj",   32'(bus.inj_count), 32'h0);
        @(negedge clk);
        rstb = 1'b1;
        step(1'b0, 1'b0);
        chk("idle_after_rst_valid", 32'(bus.out_valid), 32'h0);

        m_load(3'd0, 32'h7F);
        exp_last = '0;
        for (int i = 0; i < 18; i++) begin
            bus.prbs_mode = tbl[i].mode;
            bus.init_vals = tbl[i].seed;
            step(tbl[i].ld, tbl[i].en);
            if (tbl[i].ld) m_load(tbl[i].mode, tbl[i].seed);
            else if (tbl[i].en) begin
                m_word(w);
                exp_last = (tbl[i].kind == K_CONST) ? tbl[i].cbits : w;
            end
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(tbl[i].exp_valid));
            chk($sformatf("vec%0d_bits", i),  32'(bus.out_bits),  32'(exp_last));
        end

        // PRBS7 period: 127 words of 16 bits return to the seed.
        bus.prbs_mode = 3'd0; bus.init_vals = 32'h55;
        step(1'b1, 1'b0);
        m_load(3'd0, 32'h55);
        bad = 0; first = '0;
        for (int k = 1; k <= 128; k++) begin
            step(1'b0, 1'b1);
            m_word(w);
            if (k == 1) first = w;
            if (bus.out_bits !== w || bus.out_valid !== 1'b1) bad++;
        end
        chk("prbs7_words_bad", 32'(bad), 32'h0);
        chk("prbs7_word128_eq_word1", 32'(bus.out_bits), 32'(first));

        // Long PRBS31 run against the reference.
        bus.prbs_mode = 3'd4; bus.init_vals = 32'h2468_ACE1;
        step(1'b1, 1'b0);
        m_load(3'd4, 32'h2468_ACE1);
        bad = 0;
        for (int k = 0; k < 10000; k++) begin
            step(1'b0, 1'b1);
            m_word(w);
            if (bus.out_bits !== w) bad++;
        end
        chk("prbs31_10k_bad", 32'(bad), 32'h0);

        // Injection: period 4, lane 3, 100 words.
        bus.prbs_mode = 3'd0; bus.init_vals = 32'h3;
        bus.inj_en = 1'b1; bus.err_period = 16'd4; bus.err_lane = 4'd3;
        step(1'b1, 1'b0);
        m_load(3'd0, 32'h3);
        chk("inj_load_clear", 32'(bus.inj_count), 32'h0);
        bad = 0;
        for (int k = 1; k <= 100; k++) begin
            step(1'b0, 1'b1);
            m_word(w);
            flipm = (k % 4 == 0) ? NCH'(16'h0008) : '0;
            if (bus.out_bits !== (w ^ flipm)) bad++;
        end
        chk("inj_p4_bad", 32'(bad), 32'h0);
        chk("inj_p4_count", 32'(bus.inj_count), 32'd25);

        // Period change mid-run, inj_en pause holds the counter, period 0 disables.
        for (int k = 0; k < 13; k++) begin
            bus.inj_en = s_inj[k];
            bus.err_period = s_per[k];
            step(1'b0, 1'b1);
            m_word(w);
            flipm = s_flip[k] ? NCH'(16'h0008) : '0;
            chk($sformatf("inj_seq%0d_bits", k), 32'(bus.out_bits), 32'(w ^ flipm));
        end
        chk("inj_seq_count", 32'(bus.inj_count), 32'd28);

        bus.init_vals = 32'h9;
        step(1'b1, 1'b0);
        chk("reload_inj_clear", 32'(bus.inj_count), 32'h0);
        chk("reload_valid", 32'(bus.out_valid), 32'h0);

        // Period 1 on lane 0, then asynchronous reset mid-stream.
        bus.prbs_mode = 3'd2; bus.init_vals = 32'h1234;
        bus.inj_en = 1'b1; bus.err_period = 16'd1; bus.err_lane = 4'd0;
        step(1'b1, 1'b0);
        m_load(3'd2, 32'h1234);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b1);
            m_word(w);
            chk($sformatf("p1_word%0d", k), 32'(bus.out_bits), 32'(w ^ NCH'(1)));
        end
        chk("p1_count", 32'(bus.inj_count), 32'd3);
        #2 rstb = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
        chk("async_rst_bits",  32'(bus.out_bits),  32'h0);
        chk("async_rst_inj",   32'(bus.inj_count), 32'h0);
        @(negedge clk);
        rstb = 1'b1;
        bus.inj_en = 1'b0;
        step(1'b0, 1'b1);
        m_load(3'd0, 32'h7F);
        m_word(w);
        chk("post_rst_word", 32'(bus.out_bits), 32'(w));
        chk("post_rst_valid", 32'(bus.out_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
